// File: rtl/rot_word_serializer_if.sv
// rot_word_serializer_if: word-in / bit-out handshake bundle for the rotate-stage serializer.
//   in_word   word from the rotator          in_valid  in_word valid
//   in_ready  serializer accepts a word      ser_out   current serial bit
//   ser_valid ser_out valid                  ser_ready sink accepts ser_out
//   ser_last  final bit of the frame
// master: word producer plus bit sink (environment side).
// slave : the serializer itself.
interface rot_word_serializer_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] in_word;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;

    modport master (
        output in_word, in_valid, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last
    );

    modport slave (
        input  in_word, in_valid, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last
    );
endinterface

// File: rtl/rot_word_serializer.sv
// rot_word_serializer: takes each rotated word from the left-rotate stage and shifts it
// out one bit per clock on a valid/ready serial link, with back-to-back framing.
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       rot_word_serializer_if.slave (word input and serial output handshakes)
//   busy      frame in progress
//   frame_cnt completed frames, modulo 256
// Parameters: WIDTH (>= 2) word width; MSB_FIRST (1: bit WIDTH-1 first, 0: bit 0 first).
// Optional feature macro ROT_SER_PARITY_EN: appends an even-parity bit after the data
// bits, making every frame WIDTH+1 bits long.
module rot_word_serializer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rot_word_serializer_if.slave   bus,
    output logic                   busy,
    output logic [7:0]             frame_cnt
);

`ifdef ROT_SER_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_LEN);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] shreg;
    logic [CNT_W-1:0]     cnt;
    logic [FRAME_LEN-1:0] load_val;
    logic [FRAME_LEN-1:0] shifted;
    logic                 load_bit;
    logic                 shift_bit;
    logic                 xfer;
    logic                 accept;

    // Frame image loaded on accept; the parity bit sits at the far end from the output
    // so it leaves after all data bits.
`ifdef ROT_SER_PARITY_EN
    if (MSB_FIRST != 0) begin : g_load_msb
        assign load_val = {bus.in_word, ^bus.in_word};
    end else begin : g_load_lsb
        assign load_val = {^bus.in_word, bus.in_word};
    end
`else
    assign load_val = bus.in_word;
`endif

    // Shift toward the output end with zero fill; *_bit is the bit that will be
    // presented after a load or after a shift.
    if (MSB_FIRST != 0) begin : g_shift_msb
        assign shifted   = {shreg[FRAME_LEN-2:0], 1'b0};
        assign load_bit  = load_val[FRAME_LEN-1];
        assign shift_bit = shreg[FRAME_LEN-2];
    end else begin : g_shift_lsb
        assign shifted   = {1'b0, shreg[FRAME_LEN-1:1]};
        assign load_bit  = load_val[0];
        assign shift_bit = shreg[1];
    end

    // ser_last is only ever high in SHIFT, so this opens the input on the final transfer.
    assign bus.in_ready = (state == IDLE) || (bus.ser_last && bus.ser_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = (state == SHIFT) && bus.ser_ready;

    // Framing FSM with registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shreg         <= '0;
            cnt           <= '0;
            bus.ser_out   <= 1'b0;
            bus.ser_valid <= 1'b0;
            bus.ser_last  <= 1'b0;
            busy          <= 1'b0;
            frame_cnt     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= SHIFT;
                        shreg         <= load_val;
                        cnt           <= CNT_W'(FRAME_LEN - 1);
                        bus.ser_out   <= load_bit;
                        bus.ser_valid <= 1'b1;
                        bus.ser_last  <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (cnt == '0) begin
                            frame_cnt <= frame_cnt + 8'd1;
                            if (accept) begin
                                // back-to-back: next frame starts with no idle cycle
                                shreg        <= load_val;
                                cnt          <= CNT_W'(FRAME_LEN - 1);
                                bus.ser_out  <= load_bit;
                                bus.ser_last <= 1'b0;
                            end else begin
                                state         <= IDLE;
                                shreg         <= '0;
                                bus.ser_out   <= 1'b0;
                                bus.ser_valid <= 1'b0;
                                bus.ser_last  <= 1'b0;
                                busy          <= 1'b0;
                            end
                        end else begin
                            shreg        <= shifted;
                            cnt          <= cnt - CNT_W'(1);
                            bus.ser_out  <= shift_bit;
                            bus.ser_last <= (cnt == CNT_W'(1));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
